// File: rtl/block_pkg.sv
// Shared constants for the BLOCK readout engine: SPI command codes,
// register indices, FSM states and chain-word field placement.
package block_pkg;

    localparam logic [5:0] CODE_WR = 6'h01;
    localparam logic [5:0] CODE_RD = 6'h02;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_AVG    = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_ID     = 2'd3;

    localparam int CTRL_EN_BIT = 15;
    localparam int ST_OVF_BIT  = 0;
    localparam int ST_OVR_BIT  = 1;
    localparam int ST_LVL_LSB  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_PUSH
    } state_t;

    // Chain word is {valid, tag, data}; data sits at bit 0.
    function automatic int cw_valid_bit(input int bits_adc, input int ch_w);
        return bits_adc + ch_w;
    endfunction

endpackage

// File: rtl/block_sync_fifo.sv
// Synchronous show-ahead FIFO with flush and fill level.
// Ports: i_push/i_data write, i_pop read (o_data is head), o_full/o_empty/o_level.
module block_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 14,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LVL_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full  = (r_count == LVL_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_level = r_count;
    assign o_data  = r_mem[r_rptr];

    // A pop frees a slot in the same cycle, so push is accepted when full.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/block_readout_chain.sv
// Per-BLOCK readout: ADC capture/averaging, tagged FIFO, daisy-chain merge, SPI regs.
// Ports: SPI cmd in / data_out, adc_ready+adc_data in, chain data_from_pre -> data_to_post.
module block_readout_chain
    import block_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int BITS_ADC     = 12,
    parameter int CH_W         = 2,
    parameter int FIFO_DEPTH   = 8,
    parameter int AVG_MAX_LOG2 = 4,
    parameter int SPI_ADDR_LEN = 10,
    parameter int SPI_DATA_LEN = 16,
    parameter int SPI_CODE_LEN = 6
) (
    input  logic                         clk_3p2M,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    input  logic [SPI_CODE_LEN-1:0]      code,
    input  logic [SPI_ADDR_LEN-1:0]      addr,
    input  logic [SPI_DATA_LEN-1:0]      data_in,
    input  logic [SPI_ADDR_LEN-3:0]      reg_map_addr,
    output logic [SPI_DATA_LEN-1:0]      data_out,
    output logic                         data_out_en,
    input  logic                         adc_ready,
    input  logic [N_CH*BITS_ADC-1:0]     adc_data,
    input  logic [CH_W+BITS_ADC:0]       data_from_pre,
    output logic [CH_W+BITS_ADC:0]       data_to_post
);

    localparam int FW    = CH_W + BITS_ADC;
    localparam int VB    = cw_valid_bit(BITS_ADC, CH_W);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ACC_W = BITS_ADC + AVG_MAX_LOG2;
    localparam int CNT_W = AVG_MAX_LOG2 + 1;

    // Register file
    logic [N_CH-1:0]         r_ch_en;
    logic                    r_enable;
    logic [2:0]              r_avg_log2;
    logic                    r_fifo_ovf;
    logic                    r_seq_ovr;
    logic [SPI_DATA_LEN-1:0] r_data_out;
    logic                    r_data_out_en;

    // Capture / accumulate
    logic                    r_adc_ready_q;
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [N_CH*BITS_ADC-1:0] r_snap_data;
    logic [N_CH-1:0]         r_snap_en;
    logic [N_CH-1:0]         r_pend;
    logic [CNT_W-1:0]        r_avg_cnt;
    logic [ACC_W-1:0]        r_acc [N_CH];
    logic [BITS_ADC-1:0]     r_word [N_CH];
    logic [CH_W+BITS_ADC:0]  r_post;

    logic                    w_hit;
    logic                    w_wr;
    logic                    w_rd;
    logic [1:0]              w_reg;
    logic                    w_wr_ctrl;
    logic                    w_wr_avg;
    logic                    w_wr_stat;
    logic                    w_disable;
    logic [2:0]              w_avg_val;
    logic [SPI_DATA_LEN-1:0] w_rd_data;
    logic                    w_rise;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic [CNT_W-1:0]        w_target;
    logic [ACC_W-1:0]        w_acc_sum [N_CH];
    logic [BITS_ADC-1:0]     w_avg_word [N_CH];
    logic [CH_W-1:0]         w_idx;
    logic [N_CH-1:0]         w_pend_nxt;
    logic                    w_snap;
    logic                    w_acc_add;
    logic                    w_acc_done;
    logic                    w_push;
    logic                    w_ovr_set;
    logic                    w_ovf_set;
    logic                    w_pre_v;
    logic                    w_pop;
    logic [FW-1:0]           w_fifo_q;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [LVL_W-1:0]        w_fifo_level;
    logic                    w_unused;

    assign w_unused = ^data_in;

    // Command decode
    assign w_reg     = addr[1:0];
    assign w_hit     = cmd_valid && (addr[SPI_ADDR_LEN-1:2] == reg_map_addr);
    assign w_wr      = w_hit && (code == CODE_WR);
    assign w_rd      = w_hit && (code == CODE_RD);
    assign w_wr_ctrl = w_wr && (w_reg == REG_CTRL);
    assign w_wr_avg  = w_wr && (w_reg == REG_AVG);
    assign w_wr_stat = w_wr && (w_reg == REG_STATUS);
    assign w_disable = w_wr_ctrl && r_enable && !data_in[CTRL_EN_BIT];
    assign w_avg_val = (data_in[2:0] > 3'(AVG_MAX_LOG2)) ?
                       3'(AVG_MAX_LOG2) : data_in[2:0];

    always_comb begin
        w_rd_data = '0;
        unique case (w_reg)
            REG_CTRL: begin
                w_rd_data[N_CH-1:0]    = r_ch_en;
                w_rd_data[CTRL_EN_BIT] = r_enable;
            end
            REG_AVG:    w_rd_data[2:0] = r_avg_log2;
            REG_STATUS: begin
                w_rd_data[ST_OVF_BIT]          = r_fifo_ovf;
                w_rd_data[ST_OVR_BIT]          = r_seq_ovr;
                w_rd_data[ST_LVL_LSB +: LVL_W] = w_fifo_level;
            end
            REG_ID:     w_rd_data[SPI_ADDR_LEN-3:0] = reg_map_addr;
        endcase
    end

    // Sticky flags: a new event in the same cycle wins over the clear.
    always_ff @(posedge clk_3p2M or negedge rst_n) begin
        if (!rst_n) begin
            r_ch_en       <= '0;
            r_enable      <= 1'b0;
            r_avg_log2    <= '0;
            r_fifo_ovf    <= 1'b0;
            r_seq_ovr     <= 1'b0;
            r_data_out    <= '0;
            r_data_out_en <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ch_en  <= data_in[N_CH-1:0];
                r_enable <= data_in[CTRL_EN_BIT];
            end
            if (w_wr_avg) r_avg_log2 <= w_avg_val;
            r_fifo_ovf <= w_ovf_set |
                (r_fifo_ovf & ~(w_wr_stat & data_in[ST_OVF_BIT]));
            r_seq_ovr  <= w_ovr_set |
                (r_seq_ovr & ~(w_wr_stat & data_in[ST_OVR_BIT]));
            r_data_out    <= w_rd ? w_rd_data : '0;
            r_data_out_en <= w_rd;
        end
    end

    assign data_out    = r_data_out;
    assign data_out_en = r_data_out_en;

    // Edge detect; rises are meaningless while disabled.
    always_ff @(posedge clk_3p2M or negedge rst_n) begin
        if (!rst_n) r_adc_ready_q <= 1'b0;
        else        r_adc_ready_q <= adc_ready;
    end
    assign w_rise = adc_ready & ~r_adc_ready_q & r_enable;

    // Accumulator arithmetic
    assign w_cnt_inc = r_avg_cnt + CNT_W'(1);
    assign w_target  = CNT_W'(1) << r_avg_log2;

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_acc_sum[c]  = r_acc[c] +
                ACC_W'(r_snap_data[c*BITS_ADC +: BITS_ADC]);
            w_avg_word[c] = BITS_ADC'(w_acc_sum[c] >> r_avg_log2);
        end
    end

    // Lowest pending channel is pushed first.
    always_comb begin
        w_idx = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (r_pend[c]) w_idx = CH_W'(c);
        end
        w_pend_nxt        = r_pend;
        w_pend_nxt[w_idx] = 1'b0;
    end

    // FSM
    always_ff @(posedge clk_3p2M or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_snap      = 1'b0;
        w_acc_add   = 1'b0;
        w_acc_done  = 1'b0;
        w_push      = 1'b0;
        w_ovr_set   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_snap      = 1'b1;
                    w_state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                w_acc_add = 1'b1;
                if (w_cnt_inc < w_target) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_acc_done  = 1'b1;
                    w_state_nxt = (|r_snap_en) ? ST_PUSH : ST_IDLE;
                end
            end
            ST_PUSH: begin
                w_push    = 1'b1;
                w_ovr_set = w_rise;
                if (w_pend_nxt == '0) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_disable) begin
            w_state_nxt = ST_IDLE;
            w_push      = 1'b0;
        end
    end

    always_ff @(posedge clk_3p2M or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_data <= '0;
            r_snap_en   <= '0;
            r_pend      <= '0;
            r_avg_cnt   <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_acc[c]  <= '0;
                r_word[c] <= '0;
            end
        end else begin
            if (w_snap) begin
                r_snap_data <= adc_data;
                r_snap_en   <= r_ch_en;
            end
            if (w_acc_add) begin
                r_avg_cnt <= w_acc_done ? '0 : w_cnt_inc;
                for (int c = 0; c < N_CH; c++) begin
                    if (w_acc_done) begin
                        r_acc[c]  <= '0;
                        r_word[c] <= w_avg_word[c];
                    end else begin
                        r_acc[c] <= w_acc_sum[c];
                    end
                end
            end
            if (w_acc_done)  r_pend <= r_snap_en;
            else if (w_push) r_pend <= w_pend_nxt;
            if (w_wr_avg || w_disable) begin
                r_avg_cnt <= '0;
                for (int c = 0; c < N_CH; c++) r_acc[c] <= '0;
            end
        end
    end

    // Chain merge: upstream always wins, local FIFO fills idle slots.
    assign w_pre_v   = data_from_pre[VB];
    assign w_pop     = !w_pre_v && !w_fifo_empty && !w_disable;
    assign w_ovf_set = w_push && w_fifo_full && !w_pop;

    block_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW),
        .LVL_W (LVL_W)
    ) u_fifo (
        .i_clk   (clk_3p2M),
        .i_rst_n (rst_n),
        .i_flush (w_disable),
        .i_push  (w_push),
        .i_data  ({w_idx, r_word[w_idx]}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    always_ff @(posedge clk_3p2M or negedge rst_n) begin
        if (!rst_n)      r_post <= '0;
        else if (w_pre_v) r_post <= data_from_pre;
        else if (w_pop)   r_post <= {1'b1, w_fifo_q};
        else              r_post <= '0;
    end

    assign data_to_post = r_post;

endmodule

// File: tb/tb_block_readout_chain.sv
// Directed self-checking bench for block_readout_chain.
// Drives SPI, ADC and upstream chain; checks outputs with immediate assertions.
module tb_block_readout_chain;
    import block_pkg::*;

    logic        clk_3p2M = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [5:0]  code;
    logic [9:0]  addr;
    logic [15:0] data_in;
    logic [7:0]  reg_map_addr;
    logic [15:0] data_out;
    logic        data_out_en;
    logic        adc_ready;
    logic [47:0] adc_data;
    logic [14:0] data_from_pre;
    logic [14:0] data_to_post;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [14:0] q_out[$];
    int          q_cyc[$];

    block_readout_chain dut (
        .clk_3p2M      (clk_3p2M),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .code          (code),
        .addr          (addr),
        .data_in       (data_in),
        .reg_map_addr  (reg_map_addr),
        .data_out      (data_out),
        .data_out_en   (data_out_en),
        .adc_ready     (adc_ready),
        .adc_data      (adc_data),
        .data_from_pre (data_from_pre),
        .data_to_post  (data_to_post)
    );

    always #5 clk_3p2M = ~clk_3p2M;

    always @(posedge clk_3p2M) cyc <= cyc + 1;

    always @(negedge clk_3p2M) begin
        if (data_to_post[14]) begin
            q_out.push_back(data_to_post);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk_3p2M);
            #1;
        end
    endtask

    task automatic spi(input logic [5:0] c, input logic [1:0] r,
                       input logic [15:0] d, input logic [7:0] blk = 8'h5A);
        cmd_valid = 1'b1;
        code      = c;
        addr      = {blk, r};
        data_in   = d;
        step();
        cmd_valid = 1'b0;
        code      = '0;
        data_in   = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] r,
                          input logic [15:0] exp);
        spi(CODE_RD, r, 16'h0);
        chk({tag, "_en"}, 32'(data_out_en), 32'd1);
        chk(tag, 32'(data_out), 32'(exp));
    endtask

    task automatic pulse();
        adc_ready = 1'b1;
        step();
        adc_ready = 1'b0;
        step();
    endtask

    initial begin
        int nup;
        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        code          = '0;
        addr          = '0;
        data_in       = '0;
        reg_map_addr  = 8'h5A;
        adc_ready     = 1'b0;
        adc_data      = '0;
        data_from_pre = '0;
        step(2);
        chk("rst_post", 32'(data_to_post), 32'h0);
        chk("rst_dout", 32'(data_out), 32'h0);
        chk("rst_douten", 32'(data_out_en), 32'h0);
        rst_n = 1'b1;
        step();
        rd_chk("rst_ctrl", REG_CTRL, 16'h0000);

        // AVG clamps to 4
        spi(CODE_WR, REG_AVG, 16'h0007);
        rd_chk("avg_clamp", REG_AVG, 16'h0004);

        // 1: raw pass-through of four channels
        spi(CODE_WR, REG_AVG, 16'h0000);
        spi(CODE_WR, REG_CTRL, 16'h800F);
        adc_data = {12'h444, 12'h333, 12'h222, 12'h111};
        q_out.delete();
        q_cyc.delete();
        pulse();
        step(10);
        chk("t1_cnt", 32'(q_out.size()), 32'd4);
        if (q_out.size() == 4) begin
            chk("t1_w0", 32'(q_out[0]), 32'h4111);
            chk("t1_w1", 32'(q_out[1]), 32'h5222);
            chk("t1_w2", 32'(q_out[2]), 32'h6333);
            chk("t1_w3", 32'(q_out[3]), 32'h7444);
            chk("t1_consec", 32'(q_cyc[3] - q_cyc[0]), 32'd3);
        end

        // 2: average of four samples on ch0
        spi(CODE_WR, REG_CTRL, 16'h8001);
        spi(CODE_WR, REG_AVG, 16'h0002);
        q_out.delete();
        for (int i = 0; i < 4; i++) begin
            adc_data = {36'h0, 12'(100 + i)};
            pulse();
            step(6);
            if (i == 2) chk("t2_none_early", 32'(q_out.size()), 32'd0);
        end
        chk("t2_cnt", 32'(q_out.size()), 32'd1);
        if (q_out.size() == 1)
            chk("t2_word", 32'(q_out[0]), 32'h4000 + 32'd101);

        // 3: upstream priority
        spi(CODE_WR, REG_AVG, 16'h0000);
        spi(CODE_WR, REG_CTRL, 16'h800F);
        adc_data      = {12'h888, 12'h777, 12'h666, 12'h555};
        data_from_pre = 15'h7ABC;
        step();
        q_out.delete();
        pulse();
        step(10);
        nup = 0;
        foreach (q_out[i]) if (q_out[i] != 15'h7ABC) nup++;
        chk("t3_up_only", 32'(nup), 32'd0);
        rd_chk("t3_level", REG_STATUS, 16'h0400);
        q_out.delete();
        data_from_pre = '0;
        step(8);
        chk("t3_cnt", 32'(q_out.size()), 32'd4);
        if (q_out.size() == 4) begin
            chk("t3_w0", 32'(q_out[0]), 32'h4555);
            chk("t3_w3", 32'(q_out[3]), 32'h7888);
        end

        // 4: FIFO overflow with upstream saturated
        data_from_pre = 15'h7ABC;
        for (int i = 0; i < 3; i++) begin
            pulse();
            step(8);
        end
        rd_chk("t4_status", REG_STATUS, 16'h0801);
        spi(CODE_WR, REG_STATUS, 16'h0001);
        rd_chk("t4_w1c", REG_STATUS, 16'h0800);
        q_out.delete();
        data_from_pre = '0;
        step(12);
        chk("t4_drain", 32'(q_out.size()), 32'd8);

        // 5: rise during PUSH
        adc_data = {12'h444, 12'h333, 12'h222, 12'h111};
        q_out.delete();
        adc_ready = 1'b1;
        step();
        adc_ready = 1'b0;
        step(2);
        adc_ready = 1'b1;
        step();
        adc_ready = 1'b0;
        step(10);
        chk("t5_cnt", 32'(q_out.size()), 32'd4);
        if (q_out.size() == 4) chk("t5_w3", 32'(q_out[3]), 32'h7444);
        rd_chk("t5_ovr", REG_STATUS, 16'h0002);
        spi(CODE_WR, REG_STATUS, 16'h0002);

        // disable flushes queued words
        data_from_pre = 15'h7ABC;
        pulse();
        step(8);
        spi(CODE_WR, REG_CTRL, 16'h000F);
        q_out.delete();
        data_from_pre = '0;
        step(8);
        chk("flush_none", 32'(q_out.size()), 32'd0);
        rd_chk("flush_status", REG_STATUS, 16'h0000);

        // 6: block address decode
        spi(CODE_RD, REG_ID, 16'h0, 8'h33);
        chk("id_miss_en", 32'(data_out_en), 32'd0);
        chk("id_miss_dout", 32'(data_out), 32'd0);
        rd_chk("id_hit", REG_ID, 16'h005A);

        // async reset mid-PUSH
        spi(CODE_WR, REG_CTRL, 16'h800F);
        adc_ready = 1'b1;
        step();
        adc_ready = 1'b0;
        step(3);
        chk("rstp_pre", 32'(data_to_post), 32'h4111);
        rst_n = 1'b0;
        #1;
        chk("rstp_post", 32'(data_to_post), 32'h0);
        q_out.delete();
        step();
        rst_n = 1'b1;
        step();
        rd_chk("rstp_status", REG_STATUS, 16'h0000);
        step(6);
        chk("rstp_none", 32'(q_out.size()), 32'd0);

        // upstream passes while disabled
        data_from_pre = 15'h4123;
        step();
        chk("pass_dis", 32'(data_to_post), 32'h4123);
        data_from_pre = '0;
        step();
        chk("pass_idle", 32'(data_to_post), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
